// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for the truth-table scanner and its evaluator.
// Holds the FSM state encoding, the scan geometry and the golden tables.
package truth_table_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int ROWS  = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  localparam logic [ROWS-1:0] GOLD_X = 16'h8000;
  localparam logic [ROWS-1:0] GOLD_Y = 16'hFFFE;
  localparam logic [ROWS-1:0] GOLD_Z = 16'hE997;

endpackage

// File: rtl/truth_table_scanner_eval.sv
// Registered 4-input evaluator: x = AND, y = OR, z = 0 iff exactly two inputs set.
// Single-cycle latency from abcd to x_q/y_q/z_q; cleared by rst.
module logic_eval_reg
  import truth_table_scanner_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] abcd,
  output logic             x_q,
  output logic             y_q,
  output logic             z_q
);

  logic       x_d;
  logic       y_d;
  logic       z_d;
  logic [2:0] ones;

  always_comb begin
    ones = 3'(abcd[3]) + 3'(abcd[2]) + 3'(abcd[1]) + 3'(abcd[0]);
    x_d  = &abcd;
    y_d  = |abcd;
    z_d  = (ones != 3'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= 1'b0;
      y_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks all 16 input rows through the registered evaluator, captures x/y/z tables
// and counts rows that disagree with the expected tables latched at start.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic [ROWS-1:0]  exp_x,
  input  logic [ROWS-1:0]  exp_y,
  input  logic [ROWS-1:0]  exp_z,
  output logic [IDX_W-1:0] abcd,
  output logic             busy,
  output logic             done,
  output logic [ROWS-1:0]  tt_x,
  output logic [ROWS-1:0]  tt_y,
  output logic [ROWS-1:0]  tt_z,
  output logic [CNT_W-1:0] mism_cnt,
  output logic             pass
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cap_vld_q, cap_vld_d;
  logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
  logic [ROWS-1:0]  exp_x_q, exp_x_d, exp_y_q, exp_y_d, exp_z_q, exp_z_d;
  logic [ROWS-1:0]  tt_x_q, tt_x_d, tt_y_q, tt_y_d, tt_z_q, tt_z_d;
  logic [CNT_W-1:0] mism_q, mism_d;
  logic             pass_q, pass_d;
  logic             eval_x, eval_y, eval_z;
  logic             row_mism;

  logic_eval_reg u_eval (
    .clk  (clk),
    .rst  (rst),
    .abcd (idx_q),
    .x_q  (eval_x),
    .y_q  (eval_y),
    .z_q  (eval_z)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cap_vld_d = 1'b0;
    cap_idx_d = cap_idx_q;
    exp_x_d   = exp_x_q;
    exp_y_d   = exp_y_q;
    exp_z_d   = exp_z_q;
    tt_x_d    = tt_x_q;
    tt_y_d    = tt_y_q;
    tt_z_d    = tt_z_q;
    mism_d    = mism_q;
    pass_d    = pass_q;
    row_mism  = (eval_x != exp_x_q[cap_idx_q]) ||
                (eval_y != exp_y_q[cap_idx_q]) ||
                (eval_z != exp_z_q[cap_idx_q]);

    // Evaluator output arriving this cycle belongs to the row issued last cycle.
    if (cap_vld_q) begin
      tt_x_d[cap_idx_q] = eval_x;
      tt_y_d[cap_idx_q] = eval_y;
      tt_z_d[cap_idx_q] = eval_z;
      if (row_mism) begin
        mism_d = mism_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          tt_x_d  = '0;
          tt_y_d  = '0;
          tt_z_d  = '0;
          mism_d  = '0;
          pass_d  = 1'b0;
          exp_x_d = exp_x;
          exp_y_d = exp_y;
          exp_z_d = exp_z;
        end
      end
      ST_SCAN: begin
        if (!hold) begin
          cap_vld_d = 1'b1;
          cap_idx_d = idx_q;
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(ROWS - 1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        pass_d  = (mism_d == '0);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      exp_x_q   <= '0;
      exp_y_q   <= '0;
      exp_z_q   <= '0;
      tt_x_q    <= '0;
      tt_y_q    <= '0;
      tt_z_q    <= '0;
      mism_q    <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      exp_x_q   <= exp_x_d;
      exp_y_q   <= exp_y_d;
      exp_z_q   <= exp_z_d;
      tt_x_q    <= tt_x_d;
      tt_y_q    <= tt_y_d;
      tt_z_q    <= tt_z_d;
      mism_q    <= mism_d;
      pass_q    <= pass_d;
    end
  end

  assign abcd     = idx_q;
  assign busy     = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign tt_x     = tt_x_q;
  assign tt_y     = tt_y_q;
  assign tt_z     = tt_z_q;
  assign mism_cnt = mism_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: scenario tasks compare DUT results against a
// table model derived from the boolean definitions of x, y and z.
module tb_truth_table_scanner;
  import truth_table_scanner_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, hold;
  logic [15:0] exp_x, exp_y, exp_z;
  logic [3:0]  abcd;
  logic        busy, done, pass;
  logic [15:0] tt_x, tt_y, tt_z;
  logic [4:0]  mism_cnt;

  int checks = 0;
  int errors = 0;

  // Per-scan observations filled in by do_scan.
  int r_done_cyc, r_n_done, r_abcd_bad, r_busy_cnt, r_clear_bad, r_pass_bad;

  always #5 clk = ~clk;

  truth_table_scanner dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .exp_x(exp_x), .exp_y(exp_y), .exp_z(exp_z),
    .abcd(abcd), .busy(busy), .done(done),
    .tt_x(tt_x), .tt_y(tt_y), .tt_z(tt_z),
    .mism_cnt(mism_cnt), .pass(pass)
  );

  function automatic logic [15:0] ref_x();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = (i == 15);
    return t;
  endfunction

  function automatic logic [15:0] ref_y();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = (i != 0);
    return t;
  endfunction

  function automatic logic [15:0] ref_z();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = ($countones(4'(i)) != 2);
    return t;
  endfunction

  function automatic int ref_mism(input logic [15:0] ex, ey, ez);
    logic [15:0] rx, ry, rz;
    int n;
    rx = ref_x(); ry = ref_y(); rz = ref_z();
    n = 0;
    for (int i = 0; i < 16; i++)
      if (rx[i] != ex[i] || ry[i] != ey[i] || rz[i] != ez[i]) n++;
    return n;
  endfunction

  // Pulses start, then observes 40 cycles (cycle k = k-th cycle after the start edge).
  // Expected issue order: one new row per SCAN cycle whose hold bit is clear.
  task automatic do_scan(input logic [15:0] ex, ey, ez,
                         input logic [63:0] hmask, input logic [63:0] smask);
    int r;
    @(negedge clk);
    exp_x = ex; exp_y = ey; exp_z = ez; start = 1'b1; hold = 1'b0;
    @(negedge clk);
    start = 1'b0;
    r = 0;
    r_done_cyc = -1; r_n_done = 0; r_abcd_bad = 0;
    r_busy_cnt = 0; r_clear_bad = 0; r_pass_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (done === 1'b1) begin
        r_n_done++;
        if (r_done_cyc < 0) r_done_cyc = k;
      end
      if (busy === 1'b1) begin
        r_busy_cnt++;
        if (pass !== 1'b0) r_pass_bad++;
      end
      if (k == 1 && ({tt_x, tt_y, tt_z} !== 48'h0 || mism_cnt !== 5'd0)) r_clear_bad++;
      if (r < 16) begin
        if (abcd !== 4'(r) || busy !== 1'b1) r_abcd_bad++;
        if (!hmask[k]) r++;
      end
      hold  = hmask[k];
      start = smask[k];
    end
    hold = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; hold = 1'b1;
    exp_x = 16'hFFFF; exp_y = 16'hFFFF; exp_z = 16'hFFFF;
    repeat (3) @(negedge clk);
    checks++;
    if ({abcd, busy, done, pass, mism_cnt} !== 12'h0) begin
      errors++; $display("FAIL reset_ctrl got abcd=%h busy=%b done=%b pass=%b mism=%0d want all 0",
                         abcd, busy, done, pass, mism_cnt);
    end
    checks++;
    if ({tt_x, tt_y, tt_z} !== 48'h0) begin
      errors++; $display("FAIL reset_tables got %h %h %h want 0", tt_x, tt_y, tt_z);
    end
    rst = 1'b0; start = 1'b0; hold = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_gold();
    do_scan(GOLD_X, GOLD_Y, GOLD_Z, 64'h0, 64'h0);
    checks++;
    if (r_done_cyc != 18 || r_n_done != 1) begin
      errors++; $display("FAIL gold_done got cyc=%0d n=%0d want cyc=18 n=1", r_done_cyc, r_n_done);
    end
    checks++;
    if ({tt_x, tt_y, tt_z} !== {ref_x(), ref_y(), ref_z()} || {tt_x, tt_y, tt_z} !== 48'h8000_FFFE_E997) begin
      errors++; $display("FAIL gold_tables got %h %h %h want 8000 fffe e997", tt_x, tt_y, tt_z);
    end
    checks++;
    if (mism_cnt !== 5'd0 || pass !== 1'b1) begin
      errors++; $display("FAIL gold_pass got mism=%0d pass=%b want 0 1", mism_cnt, pass);
    end
    checks++;
    if (r_abcd_bad != 0 || r_busy_cnt != 17 || r_pass_bad != 0 || r_clear_bad != 0) begin
      errors++; $display("FAIL gold_seq got abcd_bad=%0d busy=%0d pass_bad=%0d clr_bad=%0d want 0 17 0 0",
                         r_abcd_bad, r_busy_cnt, r_pass_bad, r_clear_bad);
    end
  endtask

  task automatic test_exp_z_mismatch();
    do_scan(GOLD_X, GOLD_Y, 16'hFFFF, 64'h0, 64'h0);
    checks++;
    if (mism_cnt !== 5'd6 || 5'(ref_mism(GOLD_X, GOLD_Y, 16'hFFFF)) !== mism_cnt || pass !== 1'b0) begin
      errors++; $display("FAIL expz_mism got mism=%0d pass=%b want 6 0", mism_cnt, pass);
    end
    checks++;
    if (tt_z !== ref_z()) begin
      errors++; $display("FAIL expz_tt_z got %h want %h", tt_z, ref_z());
    end
  endtask

  task automatic test_hold();
    // Row 7 is issued in cycle 8; hold the following three cycles.
    do_scan(GOLD_X, GOLD_Y, GOLD_Z, 64'h0000_0E00, 64'h0);
    checks++;
    if (r_done_cyc != 21 || r_n_done != 1) begin
      errors++; $display("FAIL hold_done got cyc=%0d n=%0d want cyc=21 n=1", r_done_cyc, r_n_done);
    end
    checks++;
    if ({tt_x, tt_y, tt_z} !== {ref_x(), ref_y(), ref_z()} || mism_cnt !== 5'd0 || pass !== 1'b1) begin
      errors++; $display("FAIL hold_tables got %h %h %h mism=%0d want %h %h %h 0",
                         tt_x, tt_y, tt_z, mism_cnt, ref_x(), ref_y(), ref_z());
    end
    checks++;
    if (r_abcd_bad != 0 || r_busy_cnt != 20) begin
      errors++; $display("FAIL hold_rows got abcd_bad=%0d busy=%0d want 0 20", r_abcd_bad, r_busy_cnt);
    end
  endtask

  task automatic test_start_ignored();
    // start re-pulsed in SCAN (cycle 5) and during the DONE cycle (18).
    do_scan(GOLD_X, GOLD_Y, GOLD_Z, 64'h0, (64'h1 << 5) | (64'h1 << 18));
    checks++;
    if (r_done_cyc != 18 || r_n_done != 1 || r_busy_cnt != 17) begin
      errors++; $display("FAIL start_ign got cyc=%0d n=%0d busy=%0d want 18 1 17",
                         r_done_cyc, r_n_done, r_busy_cnt);
    end
    do_scan(GOLD_X, GOLD_Y, GOLD_Z, 64'h0, 64'h0);
    checks++;
    if (r_done_cyc != 18 || r_n_done != 1 || pass !== 1'b1) begin
      errors++; $display("FAIL start_second got cyc=%0d n=%0d pass=%b want 18 1 1",
                         r_done_cyc, r_n_done, pass);
    end
  endtask

  task automatic test_mid_reset();
    int nd, nb;
    @(negedge clk);
    exp_x = GOLD_X; exp_y = GOLD_Y; exp_z = GOLD_Z; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || abcd !== 4'd8) begin
      errors++; $display("FAIL mrst_pre got busy=%b abcd=%0d want 1 8", busy, abcd);
    end
    rst = 1'b1; hold = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++;
    if ({abcd, busy, done, pass, mism_cnt, tt_x, tt_y, tt_z} !== 60'h0) begin
      errors++; $display("FAIL mrst_zero got abcd=%h busy=%b done=%b mism=%0d tt=%h %h %h want 0",
                         abcd, busy, done, mism_cnt, tt_x, tt_y, tt_z);
    end
    rst = 1'b0; hold = 1'b0; start = 1'b0;
    nd = 0; nb = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
      if (busy === 1'b1) nb++;
    end
    checks++;
    if (nd != 0 || nb != 0) begin
      errors++; $display("FAIL mrst_nodone got done=%0d busy=%0d want 0 0", nd, nb);
    end
    do_scan(GOLD_X, GOLD_Y, GOLD_Z, 64'h0, 64'h0);
    checks++;
    if (r_done_cyc != 18 || {tt_x, tt_y, tt_z} !== {ref_x(), ref_y(), ref_z()} || pass !== 1'b1) begin
      errors++; $display("FAIL mrst_rescan got cyc=%0d tt=%h %h %h pass=%b", r_done_cyc, tt_x, tt_y, tt_z, pass);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ax, ay, az, bx, by, bz;
    int ma, mb;
    ax = GOLD_X ^ 16'h0001; ay = GOLD_Y; az = GOLD_Z ^ 16'h0300;
    bx = GOLD_X; by = GOLD_Y ^ 16'hF000; bz = GOLD_Z;
    ma = ref_mism(ax, ay, az);
    mb = ref_mism(bx, by, bz);
    do_scan(ax, ay, az, 64'h0, 64'h0);
    checks++;
    if (mism_cnt !== 5'(ma) || pass !== 1'b0) begin
      errors++; $display("FAIL b2b_first got mism=%0d pass=%b want %0d 0", mism_cnt, pass, ma);
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({tt_x, tt_y, tt_z} !== {ref_x(), ref_y(), ref_z()} || mism_cnt !== 5'(ma)) begin
      errors++; $display("FAIL b2b_hold got tt=%h %h %h mism=%0d want %0d", tt_x, tt_y, tt_z, mism_cnt, ma);
    end
    do_scan(bx, by, bz, 64'h0, 64'h0);
    checks++;
    if (mism_cnt !== 5'(mb) || r_clear_bad != 0 || r_done_cyc != 18) begin
      errors++; $display("FAIL b2b_second got mism=%0d clr_bad=%0d cyc=%0d want %0d 0 18",
                         mism_cnt, r_clear_bad, r_done_cyc, mb);
    end
  endtask

  task automatic test_random();
    logic [15:0] ex, ey, ez;
    logic [63:0] hm;
    int em;
    for (int it = 0; it < 8; it++) begin
      ex = GOLD_X; ey = GOLD_Y; ez = GOLD_Z;
      case ($urandom_range(0, 2))
        0: begin ex = 16'($urandom); ey = 16'($urandom); ez = 16'($urandom); end
        1: ez = GOLD_Z ^ (16'h1 << $urandom_range(0, 15));
        default: ;
      endcase
      hm = '0;
      for (int j = 2; j <= 14; j++)
        if ($urandom_range(0, 3) == 0) hm[j] = 1'b1;
      em = ref_mism(ex, ey, ez);
      do_scan(ex, ey, ez, hm, 64'h0);
      checks++;
      if (r_done_cyc != 18 + $countones(hm) || r_n_done != 1 || r_abcd_bad != 0) begin
        errors++; $display("FAIL rand_timing it=%0d got cyc=%0d n=%0d abcd_bad=%0d want cyc=%0d",
                           it, r_done_cyc, r_n_done, r_abcd_bad, 18 + $countones(hm));
      end
      checks++;
      if ({tt_x, tt_y, tt_z} !== {ref_x(), ref_y(), ref_z()} || mism_cnt !== 5'(em) || pass !== (em == 0)) begin
        errors++; $display("FAIL rand_result it=%0d got tt=%h %h %h mism=%0d pass=%b want mism=%0d",
                           it, tt_x, tt_y, tt_z, mism_cnt, pass, em);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gold();
    test_exp_z_mismatch();
    test_hold();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL: one clock, clk; reset is synchronous and active-high, rst.
REQ-002 SHALL: ports (name direction width meaning):
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  start  in  1  request a scan; sampled only in IDLE
  hold  in  1  pause row issue while in SCAN
  exp_x  in  16  expected truth table for x; latched at start
  exp_y  in  16  expected truth table for y; latched at start
  exp_z  in  16  expected truth table for z; latched at start
  abcd  out  4  current input vector driven to the evaluator; bit3=A, bit0=D
  busy  out  1  high in SCAN and DRAIN
  done  out  1  one-cycle completion pulse
  tt_x  out  16  captured x table; bit i = x for row i={A,B,C,D}
  tt_y  out  16  captured y table
  tt_z  out  16  captured z table
  mism_cnt  out  5  rows with any mismatch, range 0..16
  pass  out  1  mism_cnt==0 after the last completed scan

Function
REQ-003 SHALL: instantiate an evaluator with x=A&B&C&D, y=A|B|C|D, z=0 iff exactly two of A..D are 1. Outputs are registered, so latency is 1 cycle.
REQ-004 SHALL: FSM states IDLE, SCAN, DRAIN, DONE.
  - IDLE->SCAN on start.
  - SCAN->DRAIN after row 15 is issued.
  - DRAIN->DONE after the row 15 capture.
  - DONE->IDLE unconditionally.
REQ-005 SHALL: on entering SCAN, clear idx, tt_x/y/z and mism_cnt. Latch exp_x/y/z.
REQ-006 SHALL: in SCAN with hold=0, issue row idx (abcd=idx) and increment idx by 1.
  - With hold=1, abcd and idx are held and no row is issued.
REQ-007 SHALL: a row issued in cycle n is captured at the end of cycle n+1 into bit idx_d of tt_x/tt_y/tt_z. Tracking uses a 1-cycle valid/idx_d pipeline.
REQ-008 SHALL: mism_cnt increments by 1 per captured row where any of the three captured bits differs from the latched expected bit.
REQ-009 SHALL: idx is 4-bit. Issuing row 15 ends SCAN with no wrap-around reissue of row 0.
REQ-010 SHALL: start is ignored while not in IDLE. Start coincident with the DONE cycle is ignored.
REQ-011 SHALL: hold is ignored outside SCAN. DRAIN always completes in exactly 1 cycle.
REQ-012 SHALL: with zero hold cycles, done is high exactly 18 cycles after the edge sampling start: 16 SCAN + 1 DRAIN + 1 DONE.
REQ-013 SHALL: each hold cycle in SCAN extends the total by exactly 1 cycle.
REQ-014 SHALL: tt_x/y/z, mism_cnt and pass stay stable from DONE until the next scan starts.
REQ-015 SHALL: pass is valid from the DONE cycle and is 0 during SCAN/DRAIN.

Reset
REQ-016 SHALL: rst=1 forces IDLE with abcd=0, idx=0, busy=0, done=0, tt_x/y/z=0, mism_cnt=0, pass=0 and the pipeline valid cleared.
REQ-017 SHALL: rst mid-scan (any state) aborts the scan with no done pulse. The block is in IDLE on the cycle after rst deasserts.
REQ-018 SHALL: rst has priority over start and hold.

Structure
REQ-019 SHALL: a shared package holds the FSM state enum, ROWS=16, IDX_W=4, CNT_W=5, and the golden tables GOLD_X=16'h8000, GOLD_Y=16'hFFFE, GOLD_Z=16'hE997.
REQ-020 SHALL: one sub-module, logic_eval_reg: the registered 4-input x/y/z evaluator.

Verification
REQ-021 SHALL: start with exp = GOLD tables, no hold -> done 18 cycles after start; tt_x=8000, tt_y=FFFE, tt_z=E997, mism_cnt=0, pass=1.
REQ-022 SHALL: start with exp_z=FFFF -> mism_cnt=6 (rows 3,5,6,9,10,12), pass=0.
REQ-023 SHALL: hold=1 for 3 cycles after row 7 is issued -> done at cycle 21; tables equal GOLD, with no duplicated or skipped rows.
REQ-024 SHALL: start re-pulsed during SCAN, and start pulsed in DONE -> ignored; exactly one done pulse; second scan only after start in IDLE.
REQ-025 SHALL: rst pulse at cycle 9 of SCAN -> all outputs 0 next cycle, no done pulse. A fresh start then yields GOLD results.
REQ-026 SHALL: back-to-back scans with differing exp values -> the second scan reports against its own latched exp. The first scan's results hold until the second scan enters SCAN.
